// File: rtl/led_shift_arbiter.sv
// Round-robin arbiter sharing one serial LED shift chain among NREQ requesters.
// The granted word is shifted MSB-first on led_clk/led_sout, then re-latched via LED_PEN.
module led_shift_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  done,
    output logic                  led_clk,
    output logic                  led_sout,
    output logic                  led_clrn,
    output logic                  LED_PEN
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] LAST_REQ = PW'(NREQ - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_DIV = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

    state_t           state, state_n;
    logic [PW-1:0]    ptr, ptr_n, sel, sel_n;
    logic [PW-1:0]    hit, idx_w;
    logic             found;
    int               idx;
    logic [WIDTH-1:0] shreg, shreg_n, word;
    logic [BW-1:0]    bitcnt, bitcnt_n;
    logic [CW-1:0]    divcnt, divcnt_n;
    logic [NREQ-1:0]  gnt_n;
    logic             busy_n, done_n, led_clk_n, led_sout_n, led_clrn_n, led_pen_n;

    assign word = data[int'(sel)*WIDTH +: WIDTH];

    // Rotating-priority scan: first set request at or after ptr wins.
    always_comb begin
        found = 1'b0;
        hit   = '0;
        idx   = 0;
        idx_w = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx   = (int'(ptr) + i) % NREQ;
            idx_w = PW'(idx);
            if (!found && req[idx_w]) begin
                found = 1'b1;
                hit   = idx_w;
            end
        end
    end

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        sel_n      = sel;
        shreg_n    = shreg;
        bitcnt_n   = bitcnt;
        divcnt_n   = divcnt;
        gnt_n      = gnt;
        busy_n     = busy;
        done_n     = 1'b0;
        led_clk_n  = led_clk;
        led_sout_n = led_sout;
        led_clrn_n = 1'b1;
        led_pen_n  = LED_PEN;
        case (state)
            IDLE: begin
                led_pen_n = 1'b1;
                if (found) begin
                    sel_n   = hit;
                    gnt_n   = NREQ'(1) << hit;
                    busy_n  = 1'b1;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                shreg_n    = word;
                led_sout_n = word[WIDTH-1];
                bitcnt_n   = LAST_BIT;
                divcnt_n   = '0;
                led_clk_n  = 1'b0;
                led_pen_n  = 1'b0;
                ptr_n      = (sel == LAST_REQ) ? '0 : sel + 1'b1;
                state_n    = SHIFT;
            end
            SHIFT: begin
                // Each bit: CLK_DIV cycles low, CLK_DIV high; data moves only on the falling edge.
                if (divcnt == LAST_DIV) begin
                    divcnt_n = '0;
                    if (!led_clk) begin
                        led_clk_n = 1'b1;
                    end else begin
                        led_clk_n = 1'b0;
                        shreg_n   = shreg << 1;
                        if (bitcnt == '0) begin
                            led_pen_n = 1'b1;
                            done_n    = 1'b1;
                            state_n   = LATCH;
                        end else begin
                            led_sout_n = shreg[WIDTH-2];
                            bitcnt_n   = bitcnt - 1'b1;
                        end
                    end
                end else begin
                    divcnt_n = divcnt + 1'b1;
                end
            end
            LATCH: begin
                gnt_n   = '0;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            sel      <= '0;
            shreg    <= '0;
            bitcnt   <= '0;
            divcnt   <= '0;
            gnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            led_clk  <= 1'b0;
            led_sout <= 1'b0;
            led_clrn <= 1'b0;
            LED_PEN  <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            sel      <= sel_n;
            shreg    <= shreg_n;
            bitcnt   <= bitcnt_n;
            divcnt   <= divcnt_n;
            gnt      <= gnt_n;
            busy     <= busy_n;
            done     <= done_n;
            led_clk  <= led_clk_n;
            led_sout <= led_sout_n;
            led_clrn <= led_clrn_n;
            LED_PEN  <= led_pen_n;
        end
    end

endmodule

// File: tb/tb_led_shift_arbiter.sv
// Bench for led_shift_arbiter: transfer-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations and a small WIDTH=2/CLK_DIV=1 instance.
module tb_led_shift_arbiter;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 16;
    localparam int CLK_DIV = 4;
    localparam int NSHIFT  = 2 * CLK_DIV * WIDTH;
    localparam int BWT     = $clog2(WIDTH);

    logic                  clk, rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data;
    logic [NREQ-1:0]       gnt;
    logic                  busy, done, led_clk, led_sout, led_clrn, LED_PEN;

    logic [1:0] req2, gnt2;
    logic [3:0] data2;
    logic       busy2, done2, led_clk2, led_sout2, led_clrn2, led_pen2;

    led_shift_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .req(req), .data(data), .gnt(gnt), .busy(busy),
        .done(done), .led_clk(led_clk), .led_sout(led_sout), .led_clrn(led_clrn),
        .LED_PEN(LED_PEN)
    );

    led_shift_arbiter #(.NREQ(2), .WIDTH(2), .CLK_DIV(1)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .data(data2), .gnt(gnt2), .busy(busy2),
        .done(done2), .led_clk(led_clk2), .led_sout(led_sout2), .led_clrn(led_clrn2),
        .LED_PEN(led_pen2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total, bad, cyc;

    // Reference model state: a transfer is described only by its start cycle, requester and word.
    bit              m_valid, m_inreset, m_active;
    int              m_start, m_k, m_ptr, k_sel;
    logic [WIDTH-1:0] m_word;

    logic [NREQ-1:0] e_gnt;
    logic            e_busy, e_done, e_clk, e_clrn, e_pen, e_sout;
    bit              chk_sout;
    int              o, j;

    int              done_cnt, pen_low_cnt, hi_rise_cnt;
    logic [WIDTH-1:0] rx;
    int              gnt_cyc_q[$];
    logic [NREQ-1:0] gnt_val_q[$];
    int              done_cyc_q[$];
    logic            prev_busy, prev_clk;

    int t, t2, n0, d0, p0, h0;
    bit e6_clk[8]  = '{0, 0, 0, 1, 0, 1, 0, 0};
    bit e6_busy[8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    bit e6_done[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    bit e6_sout[8] = '{0, 0, 1, 1, 0, 0, 0, 0};

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] r, output int tstart);
        req    = r;
        tstart = cyc;
    endtask

    task automatic waitDone(input string name, input int budget);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin
            tick();
            n++;
        end
        checkOutput({name, " done seen"}, 64'(done_cnt != start), 64'(1));
    endtask

    task automatic applyReset();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checkOutput("reset gnt", 64'(gnt), 64'(0));
        checkOutput("reset busy", 64'(busy), 64'(0));
        checkOutput("reset clrn", 64'(led_clrn), 64'(0));
        checkOutput("reset pen", 64'(LED_PEN), 64'(0));
        rst = 1'b0;
        tick();
        @(negedge clk);
        checkOutput("post-reset clrn", 64'(led_clrn), 64'(1));
        checkOutput("post-reset pen", 64'(LED_PEN), 64'(1));
        tick();
    endtask

    initial begin
        rst = 1'b1; req = '0; data = '0; req2 = '0; data2 = '0;
        total = 0; bad = 0; cyc = 0;
        m_valid = 0; m_inreset = 0; m_active = 0; m_ptr = 0; m_k = 0; m_start = 0; m_word = '0;
        done_cnt = 0; pen_low_cnt = 0; hi_rise_cnt = 0; rx = '0;
        prev_busy = 1'b0; prev_clk = 1'b0;

        fork
            // Model: advance one cycle, deciding grants from the round-robin rule.
            forever begin
                @(posedge clk);
                cyc++;
                if (rst) begin
                    m_valid = 1; m_inreset = 1; m_active = 0; m_ptr = 0;
                end else begin
                    m_inreset = 0;
                    if (!m_active) begin
                        if (m_valid && req != '0) begin
                            k_sel = -1;
                            for (int i = 0; i < NREQ; i++)
                                if (k_sel < 0 && ((req >> ((m_ptr + i) % NREQ)) & NREQ'(1)) != '0)
                                    k_sel = (m_ptr + i) % NREQ;
                            m_k = k_sel; m_active = 1; m_start = cyc; m_ptr = (k_sel + 1) % NREQ;
                        end
                    end else begin
                        o = cyc - m_start;
                        if (o == 1) m_word = data[m_k*WIDTH +: WIDTH];
                        if (o == NSHIFT + 2) m_active = 0;
                    end
                end
            end
            // Compare every cycle against the model, then collect transfer statistics.
            forever begin
                @(negedge clk);
                if (m_valid) begin
                    e_gnt = '0; e_busy = 0; e_done = 0; e_clk = 0; e_clrn = 1; e_pen = 1;
                    e_sout = 0; chk_sout = 0;
                    if (m_inreset) begin
                        e_clrn = 0; e_pen = 0; chk_sout = 1;
                    end else if (m_active) begin
                        o = cyc - m_start;
                        e_gnt = NREQ'(1) << m_k;
                        e_busy = 1;
                        if (o >= 1 && o <= NSHIFT) begin
                            j = o - 1;
                            e_pen = 0;
                            e_clk = (j % (2*CLK_DIV)) >= CLK_DIV;
                            e_sout = m_word[BWT'(WIDTH - 1 - j/(2*CLK_DIV))];
                            chk_sout = 1;
                        end else if (o == NSHIFT + 1) begin
                            e_done = 1;
                        end
                    end
                    checkOutput("gnt", 64'(gnt), 64'(e_gnt));
                    checkOutput("busy", 64'(busy), 64'(e_busy));
                    checkOutput("done", 64'(done), 64'(e_done));
                    checkOutput("led_clk", 64'(led_clk), 64'(e_clk));
                    checkOutput("led_clrn", 64'(led_clrn), 64'(e_clrn));
                    checkOutput("LED_PEN", 64'(LED_PEN), 64'(e_pen));
                    if (chk_sout) checkOutput("led_sout", 64'(led_sout), 64'(e_sout));
                end
                if (busy === 1'b1 && prev_busy !== 1'b1) begin
                    gnt_cyc_q.push_back(cyc);
                    gnt_val_q.push_back(gnt);
                end
                if (done === 1'b1) begin
                    done_cnt++;
                    done_cyc_q.push_back(cyc);
                end
                if (led_clk === 1'b1 && prev_clk === 1'b0) begin
                    rx = {rx[WIDTH-2:0], led_sout};
                    if (led_sout === 1'b1) hi_rise_cnt++;
                end
                if (LED_PEN === 1'b0) pen_low_cnt++;
                prev_busy = busy;
                prev_clk  = led_clk;
            end
            begin
                #2000000;
                $display("[TB] FAIL watchdog: simulation time limit reached");
                $fatal(1, "[TB] watchdog");
            end
        join_none

        // Single requester, word A5C3: latency, serial bits, PEN-low window.
        applyReset();
        data[15:0] = 16'hA5C3;
        n0 = gnt_cyc_q.size(); p0 = pen_low_cnt;
        applyStimulus(4'b0001, t);
        tick(); req = '0;
        waitDone("t1", 200);
        checkOutput("t1 grant count", 64'(gnt_cyc_q.size() - n0), 64'(1));
        if (gnt_cyc_q.size() > n0) begin
            checkOutput("t1 gnt latency", 64'(gnt_cyc_q[n0] - t), 64'(1));
            checkOutput("t1 gnt value", 64'(gnt_val_q[n0]), 64'(4'b0001));
        end
        checkOutput("t1 done latency", 64'(done_cyc_q[$] - t), 64'(130));
        checkOutput("t1 bits", 64'(rx), 64'(16'hA5C3));
        checkOutput("t1 pen low cycles", 64'(pen_low_cnt - p0), 64'(128));

        // All requesting: order 0,1,2,3,0 with a fixed done-to-done spacing.
        applyReset();
        data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        n0 = gnt_val_q.size(); d0 = done_cyc_q.size();
        applyStimulus(4'b1111, t);
        repeat (5) waitDone("t2", 200);
        req = '0;
        checkOutput("t2 grant count", 64'(gnt_val_q.size() - n0), 64'(5));
        if (gnt_val_q.size() >= n0 + 5) begin
            checkOutput("t2 gnt0", 64'(gnt_val_q[n0]),   64'(4'b0001));
            checkOutput("t2 gnt1", 64'(gnt_val_q[n0+1]), 64'(4'b0010));
            checkOutput("t2 gnt2", 64'(gnt_val_q[n0+2]), 64'(4'b0100));
            checkOutput("t2 gnt3", 64'(gnt_val_q[n0+3]), 64'(4'b1000));
            checkOutput("t2 gnt4", 64'(gnt_val_q[n0+4]), 64'(4'b0001));
        end
        if (done_cyc_q.size() >= d0 + 5)
            for (int i = 1; i < 5; i++)
                checkOutput("t2 done gap", 64'(done_cyc_q[d0+i] - done_cyc_q[d0+i-1]), 64'(131));

        // Grant 1 moves the pointer to 2, so 1001 resolves to 3 then 0.
        applyStimulus(4'b0010, t);
        tick(); req = '0;
        waitDone("t3a", 200);
        checkOutput("t3 gnt1", 64'(gnt_val_q[$]), 64'(4'b0010));
        n0 = gnt_val_q.size();
        applyStimulus(4'b1001, t);
        repeat (2) waitDone("t3", 200);
        req = '0;
        checkOutput("t3 grant count", 64'(gnt_val_q.size() - n0), 64'(2));
        if (gnt_val_q.size() >= n0 + 2) begin
            checkOutput("t3 first", 64'(gnt_val_q[n0]),   64'(4'b1000));
            checkOutput("t3 second", 64'(gnt_val_q[n0+1]), 64'(4'b0001));
        end

        // One-cycle request pulse still yields a full transfer of 0001.
        data[15:0] = 16'h0001;
        d0 = done_cnt; h0 = hi_rise_cnt;
        applyStimulus(4'b0001, t);
        tick(); req = '0;
        waitDone("t4", 200);
        repeat (10) tick();
        checkOutput("t4 done count", 64'(done_cnt - d0), 64'(1));
        checkOutput("t4 bits", 64'(rx), 64'(16'h0001));
        checkOutput("t4 high bits", 64'(hi_rise_cnt - h0), 64'(1));

        // Reset in the middle of bit 7 aborts silently; pointer returns to 0.
        data[15:0] = 16'hFFFF;
        d0 = done_cnt;
        applyStimulus(4'b0001, t);
        tick(); req = '0;
        repeat (59) tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("t5 abort gnt", 64'(gnt), 64'(0));
        checkOutput("t5 abort busy", 64'(busy), 64'(0));
        checkOutput("t5 abort clrn", 64'(led_clrn), 64'(0));
        checkOutput("t5 abort pen", 64'(LED_PEN), 64'(0));
        rst = 1'b0;
        tick();
        applyStimulus(4'b0110, t2);
        tick();
        @(negedge clk);
        checkOutput("t5 regrant", 64'(gnt), 64'(4'b0010));
        req = '0;
        waitDone("t5", 200);
        checkOutput("t5 done count", 64'(done_cnt - d0), 64'(1));

        // Minimal instance: WIDTH=2, CLK_DIV=1, word 10, done six cycles after request.
        tick();
        data2 = 4'b0010;
        req2  = 2'b01;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("t6 led_clk", 64'(led_clk2), 64'(e6_clk[i]));
            checkOutput("t6 busy", 64'(busy2), 64'(e6_busy[i]));
            checkOutput("t6 done", 64'(done2), 64'(e6_done[i]));
            if (i >= 2 && i <= 5) checkOutput("t6 sout", 64'(led_sout2), 64'(e6_sout[i]));
            if (i == 0) checkOutput("t6 clrn", 64'(led_clrn2), 64'(1));
            if (i == 1) begin
                checkOutput("t6 gnt", 64'(gnt2), 64'(2'b01));
                req2 = '0;
            end
            if (i == 3) checkOutput("t6 pen", 64'(led_pen2), 64'(0));
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
